// File: rtl/ram_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ram_fifo
//  Purpose  : Parametrised synchronous FIFO on an inferred simple dual-port
//             RAM. Pointer-managed ordering, occupancy count, full/empty and
//             programmable almost flags, sticky overflow/underflow errors.
//  Ports    : clk          - single clock, all state on rising edge
//             reset        - asynchronous, active-high
//             wr_en        - write request
//             wr_data      - write word
//             rd_en        - read request
//             rd_data      - registered read word (1 clk latency)
//             rd_valid     - rd_data updated this cycle (1-cycle pulse)
//             count        - occupancy 0..DEPTH
//             full/empty   - count == DEPTH / count == 0
//             almost_full  - count >= AF_LEVEL
//             almost_empty - count <= AE_LEVEL
//             overflow     - sticky: write attempted while full
//             underflow    - sticky: read attempted while empty
//             clr_err      - synchronous clear of overflow/underflow
//  Revision : 1.0 - initial release
// ============================================================================
module ram_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                c_DEPTH_INT = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   c_AF      = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_AE      = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Storage is deliberately not reset so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH_INT];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags derive only from the registered count, so accept decisions use
  // pre-edge state and a full/empty FIFO can never alias rd_ptr == wr_ptr.
  assign w_full   = (r_count == c_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;

      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase

      // A new error event takes priority over a coincident clear.
      r_overflow  <= (wr_en && w_full)  || (r_overflow  && !clr_err);
      r_underflow <= (rd_en && w_empty) || (r_underflow && !clr_err);
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_AF);
  assign almost_empty = (r_count <= c_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_fifo
//  Purpose  : Self-checking bench for ram_fifo. A reference queue models the
//             FIFO; words read out are pushed to a scoreboard when the read
//             is driven and popped when the DUT raises rd_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_fifo;

  localparam int c_DW    = 4;
  localparam int c_AW    = 5;
  localparam int c_DEPTH = 32;
  localparam int c_AF    = 28;
  localparam int c_AE    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [c_DW-1:0]   wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [c_DW-1:0]   rd_data;
  logic              rd_valid;
  logic [c_AW:0]     count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  ram_fifo #(
    .DATA_WIDTH(c_DW),
    .ADDR_WIDTH(c_AW),
    .AF_LEVEL  (c_AF),
    .AE_LEVEL  (c_AE)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [c_DW-1:0] m_fifo [$];
  logic [c_DW-1:0] sb     [$];
  logic [c_DW-1:0] m_rd_data;
  logic            m_ovf;
  logic            m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    sb.delete();
    m_rd_data = '0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
  endtask

  task automatic check_outputs(input bit exp_valid);
    int c;
    c = m_fifo.size();
    chk("count",        32'(count),        32'(c));
    chk("full",         32'(full),         32'(c == c_DEPTH));
    chk("empty",        32'(empty),        32'(c == 0));
    chk("almost_full",  32'(almost_full),  32'(c >= c_AF));
    chk("almost_empty", 32'(almost_empty), 32'(c <= c_AE));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
    chk("rd_valid",     32'(rd_valid),     32'(exp_valid));
    if (rd_valid) begin
      if (sb.size() == 0) chk("sb_underrun", 32'(sb.size()), 32'd1);
      else                chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
    end else begin
      chk("rd_hold", 32'(rd_data), 32'(m_rd_data));
    end
  endtask

  // One clock of stimulus: drive, predict from pre-edge model state, check after edge.
  task automatic cycle(input bit w, input logic [c_DW-1:0] d, input bit r, input bit c);
    bit full_b, empty_b, acc_w, acc_r;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    full_b  = (m_fifo.size() == c_DEPTH);
    empty_b = (m_fifo.size() == 0);
    acc_w   = w && !full_b;
    acc_r   = r && !empty_b;
    if (acc_r) begin
      m_rd_data = m_fifo.pop_front();
      sb.push_back(m_rd_data);
    end
    if (acc_w) m_fifo.push_back(d);
    m_ovf = (w && full_b)  || (m_ovf && !c);
    m_udf = (r && empty_b) || (m_udf && !c);
    @(posedge clk);
    #1;
    check_outputs(acc_r);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Fill with 0..F,0..F
    for (int i = 0; i < 32; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);

    // Write at full: rejected, overflow sticky, set beats clear, then clear
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);

    // Drain in order
    for (int i = 0; i < 32; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Read at empty: underflow, rd_data held
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);

    // Simultaneous write+read on empty: write only, underflow set
    cycle(1'b1, 4'h7, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);

    // Count 5, then 40 cycles of simultaneous traffic wrapping the pointers
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'($urandom_range(15)), 1'b1, 1'b0);

    // Fill, then simultaneous at full: read only, overflow set
    for (int i = 0; i < 27; i++) cycle(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
    cycle(1'b1, 4'hC, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);

    // Drain to 12, keep a burst going, then reset between edges
    for (int i = 0; i < 19; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 4'h5, 1'b1, 1'b0);
    cycle(1'b1, 4'h6, 1'b1, 1'b0);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(negedge clk);
    reset = 1'b0;

    // First read after reset returns the new word
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
